// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Takes 2-byte command frames from an RX byte stream, drives the
//               4-bit ALU, waits out its settle time and replies on a TX stream.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_r,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_pulse
);

    localparam int              TMO_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] c_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    // The settle counter runs 0..SETTLE_CYCLES, giving SETTLE_CYCLES+1 clocks
    // from the operand update edge to tx_valid.
    localparam logic [3:0]      c_SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [7:0]      c_ERR_BYTE    = 8'hEE;
    localparam logic [5:0]      c_HDR_PREFIX  = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GET_AB = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rx_ready;
    logic [1:0]         r_op_latch,  w_op_latch_next;
    logic [1:0]         r_alu_op,    w_alu_op_next;
    logic [3:0]         r_alu_a,     w_alu_a_next;
    logic [3:0]         r_alu_b,     w_alu_b_next;
    logic [7:0]         r_tx_data,   w_tx_data_next;
    logic               r_err,       w_err_next;
    logic [TMO_W-1:0]   r_tmo_cnt,   w_tmo_cnt_next;
    logic [3:0]         r_set_cnt,   w_set_cnt_next;
    logic               w_rx_fire;

    assign w_rx_fire = rx_valid & r_rx_ready;

    always_comb begin
        w_next_state    = r_state;
        w_op_latch_next = r_op_latch;
        w_alu_op_next   = r_alu_op;
        w_alu_a_next    = r_alu_a;
        w_alu_b_next    = r_alu_b;
        w_tx_data_next  = r_tx_data;
        w_err_next      = 1'b0;
        w_tmo_cnt_next  = r_tmo_cnt;
        w_set_cnt_next  = r_set_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (rx_data[7:2] == c_HDR_PREFIX) begin
                        w_op_latch_next = rx_data[1:0];
                        w_tmo_cnt_next  = '0;
                        w_next_state    = ST_GET_AB;
                    end else begin
                        w_err_next     = 1'b1;
                        w_tx_data_next = c_ERR_BYTE;
                        w_next_state   = ST_RESP;
                    end
                end
            end
            ST_GET_AB: begin
                if (w_rx_fire) begin
                    w_alu_a_next   = rx_data[7:4];
                    w_alu_b_next   = rx_data[3:0];
                    w_alu_op_next  = r_op_latch;
                    w_set_cnt_next = '0;
                    w_next_state   = ST_SETTLE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_err_next     = 1'b1;
                    w_tx_data_next = c_ERR_BYTE;
                    w_next_state   = ST_RESP;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_set_cnt == c_SETTLE_LAST) begin
                    w_tx_data_next = {4'h5, alu_r};
                    w_next_state   = ST_RESP;
                end else begin
                    w_set_cnt_next = r_set_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_op_latch <= 2'b00;
            r_alu_op   <= 2'b00;
            r_alu_a    <= 4'h0;
            r_alu_b    <= 4'h0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
            r_tmo_cnt  <= '0;
            r_set_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered so the upstream sees a glitch-free ready derived from the coming state.
            r_rx_ready <= (w_next_state == ST_IDLE) || (w_next_state == ST_GET_AB);
            r_op_latch <= w_op_latch_next;
            r_alu_op   <= w_alu_op_next;
            r_alu_a    <= w_alu_a_next;
            r_alu_b    <= w_alu_b_next;
            r_tx_data  <= w_tx_data_next;
            r_err      <= w_err_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
            r_set_cnt  <= w_set_cnt_next;
        end
    end

    assign rx_ready  = r_rx_ready;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign tx_data   = r_tx_data;
    assign tx_valid  = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign err_pulse = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int SETTLE = 2;
    localparam int TMO    = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [1:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_r;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       err_pulse;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err_cnt = 0;

    alu_cmd_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_r    (alu_r),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'b00:   alu_r = alu_a & alu_b;
            2'b01:   alu_r = alu_a ^ alu_b;
            2'b10:   alu_r = alu_a - alu_b;
            default: alu_r = alu_a * alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (err_pulse) err_cnt++;
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got %0h, required none", tx_data);
                end else begin
                    mon_e = q.pop_front();
                    check("response", {14'h0, tx_data, alu_op, alu_a, alu_b}, {14'h0, mon_e});
                end
            end
        end
    end

    task automatic check_reset(input string name);
        check(name, {10'h0, rx_ready, busy, tx_valid, err_pulse, tx_data, alu_op, alu_a, alu_b}, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (k == 200) begin
            check("rx_handshake_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.d = d; e.op = op; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] d,
                         input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        push(d, op, a, b);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (!busy && q.size() == 0) break;
        end
        if (k == 3000) check(name, 32'd1, 32'd0);
    endtask

    task automatic wait_tx_valid(input int limit, output int n);
        n = 0;
        while (!tx_valid && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e0;
        int bad;

        repeat (3) @(posedge clk);
        #1 check_reset("reset_initial");
        rst = 1'b0;

        // AND frame and settle latency
        push(8'h58, 2'b00, 4'hC, 4'hA);
        send_byte(8'hA0);
        send_byte(8'hCA);
        wait_tx_valid(50, n);
        check("settle_latency", n, SETTLE + 1);
        wait_idle("idle_after_and");
        check("busy_after_and", {31'h0, busy}, 32'h0);

        // Back-to-back frames over all ops, including SUB/MUL wraparound
        frame(8'hA1, 8'hCA, 8'h56, 2'b01, 4'hC, 4'hA);
        frame(8'hA2, 8'h53, 8'h52, 2'b10, 4'h5, 4'h3);
        frame(8'hA3, 8'h32, 8'h56, 2'b11, 4'h3, 4'h2);
        frame(8'hA2, 8'h24, 8'h5E, 2'b10, 4'h2, 4'h4);
        frame(8'hA3, 8'hF1, 8'h5F, 2'b11, 4'hF, 4'h1);
        wait_idle("idle_after_burst");

        // Bad header
        e0 = err_cnt;
        push(8'hEE, 2'b11, 4'hF, 4'h1);
        send_byte(8'h7F);
        wait_idle("idle_after_bad_hdr");
        check("bad_hdr_err_count", err_cnt, e0 + 1);
        check("bad_hdr_operands", {22'h0, alu_op, alu_a, alu_b}, {22'h0, 2'b11, 4'hF, 4'h1});
        frame(8'hA1, 8'hCA, 8'h56, 2'b01, 4'hC, 4'hA);
        wait_idle("idle_after_recover");

        // Timeout between byte 0 and byte 1
        e0 = err_cnt;
        push(8'hEE, 2'b01, 4'hC, 4'hA);
        send_byte(8'hA3);
        wait_tx_valid(TMO + 100, n);
        check("timeout_cycles", n, TMO);
        wait_idle("idle_after_timeout");
        check("timeout_err_count", err_cnt, e0 + 1);
        frame(8'hA0, 8'hFF, 8'h5F, 2'b00, 4'hF, 4'hF);
        wait_idle("idle_after_timeout_recover");

        // Response stalled by tx_ready while upstream pokes rx_valid
        tx_ready = 1'b0;
        e0 = err_cnt;
        frame(8'hA2, 8'h53, 8'h52, 2'b10, 4'h5, 4'h3);
        wait_tx_valid(50, n);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            rx_data  = 8'h7F;
            rx_valid = i[0];
            @(negedge clk);
            if (rx_ready || !tx_valid || tx_data !== 8'h52) bad++;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check("stall_stable", bad, 0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_idle", {30'h0, tx_valid, busy}, 32'h0);
        check("stall_no_byte_consumed", err_cnt, e0);
        frame(8'hA1, 8'hF0, 8'h5F, 2'b01, 4'hF, 4'h0);
        wait_idle("idle_after_stall");

        // Reset during SETTLE
        send_byte(8'hA3);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset("reset_in_settle");
        rst = 1'b0;
        frame(8'hA3, 8'h33, 8'h59, 2'b11, 4'h3, 4'h3);
        wait_idle("idle_after_settle_reset");

        // Reset during RESP with a pending byte
        tx_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'hF3);
        wait_tx_valid(50, n);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset("reset_in_resp");
        rst = 1'b0;
        tx_ready = 1'b1;
        frame(8'hA1, 8'h5A, 8'h5F, 2'b01, 4'h5, 4'hA);
        wait_idle("idle_after_resp_reset");

        repeat (5) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
